operand_select_stage: RTL and testbench

Parametrised, registered successor of the data-select stage. It sits between decode and execute: it reads rs1/rs2 via regfile read ports and resolves forwarding from NUM_FW pipeline sources by priority. It stalls on non-forwardable hazards, builds op1/op2/rs2 data, and registers the result behind a valid/ready output handshake with flush. It also keeps a saturating hazard-stall counter for performance monitoring.

---
 rtl/operand_select_stage.sv | 193 +++++++++++++++++++
 tb/tb_operand_select_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_select_stage.sv
// Operand select stage between decode and execute. It reads the register file,
// resolves forwarding by priority, stalls on hazards and registers the operands.
module operand_select_stage #(
  parameter int XLEN   = 32,
  parameter int NUM_FW = 3,
  parameter int RA_W   = 5,
  parameter int ID_W   = 64,
  parameter int CTRL_W = 48,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  // decode side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic [ID_W-1:0]          in_id,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [1:0]               in_op1_sel,
  input  logic [2:0]               in_op2_sel,
  input  logic [XLEN-1:0]          in_imm_i,
  input  logic [XLEN-1:0]          in_imm_s,
  input  logic [XLEN-1:0]          in_imm_b,
  input  logic [XLEN-1:0]          in_imm_j,
  input  logic [XLEN-1:0]          in_imm_u,
  input  logic [XLEN-1:0]          in_imm_z,
  // register file read ports
  output logic [RA_W-1:0]          rf_rs1_addr,
  output logic [RA_W-1:0]          rf_rs2_addr,
  input  logic [XLEN-1:0]          rf_rs1_rdata,
  input  logic [XLEN-1:0]          rf_rs2_rdata,
  // forwarding sources, index 0 youngest
  input  logic [NUM_FW-1:0]        fw_valid,
  input  logic [NUM_FW-1:0]        fw_can_forward,
  input  logic [NUM_FW*RA_W-1:0]   fw_addr,
  input  logic [NUM_FW*XLEN-1:0]   fw_wdata,
  input  logic                     flush,
  // execute side
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [ID_W-1:0]          out_id,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [XLEN-1:0]          out_imm_i,
  output logic [XLEN-1:0]          out_imm_b,
  output logic [XLEN-1:0]          out_imm_j,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [XLEN-1:0]          out_rs2,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_IMZ  = 2'd2,
    OP1_ZERO = 2'd3
  } op1_sel_e;

  typedef enum logic [2:0] {
    OP2_RS2 = 3'd0,
    OP2_IMI = 3'd1,
    OP2_IMS = 3'd2,
    OP2_IMJ = 3'd3,
    OP2_IMU = 3'd4
  } op2_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic [ID_W-1:0]   id;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   rs2;
  } payload_t;

  logic [RA_W-1:0]   rs1_addr;
  logic [RA_W-1:0]   rs2_addr;
  logic [NUM_FW-1:0] hit_rs1;
  logic [NUM_FW-1:0] hit_rs2;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              hazard;
  logic              load;
  payload_t          out_d;
  payload_t          out_q;
  logic              out_valid_q;

  assign rs1_addr    = RA_W'(in_inst[19:15]);
  assign rs2_addr    = RA_W'(in_inst[24:20]);
  assign rf_rs1_addr = rs1_addr;
  assign rf_rs2_addr = rs2_addr;

  // Per-source address match; x0 never matches so it can never stall or forward.
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    for (int k = 0; k < NUM_FW; k++) begin
      hit_rs1[k] = fw_valid[k] && (fw_addr[k*RA_W +: RA_W] == rs1_addr) && (rs1_addr != '0);
      hit_rs2[k] = fw_valid[k] && (fw_addr[k*RA_W +: RA_W] == rs2_addr) && (rs2_addr != '0);
    end
  end

  // Walk from oldest to youngest so the lowest-index hit is the last writer.
  // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    rs1_val = rf_rs1_rdata;
    rs2_val = rf_rs2_rdata;
    for (int k = NUM_FW - 1; k >= 0; k--) begin
      if (hit_rs1[k]) rs1_val = fw_wdata[k*XLEN +: XLEN];
      if (hit_rs2[k]) rs2_val = fw_wdata[k*XLEN +: XLEN];
    end
    if (rs1_addr == '0) rs1_val = '0;
    if (rs2_addr == '0) rs2_val = '0;
  end

  // Any matching source without ready data blocks issue, even if a younger one forwards.
  assign hazard   = in_valid && (|((hit_rs1 | hit_rs2) & ~fw_can_forward));
  assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
  assign load     = in_valid && in_ready;

  always_comb begin
    out_d       = '0;
    out_d.pc    = in_pc;
    out_d.inst  = in_inst;
    out_d.id    = in_id;
    out_d.ctrl  = in_ctrl;
    out_d.imm_i = in_imm_i;
    out_d.imm_b = in_imm_b;
    out_d.imm_j = in_imm_j;
    out_d.rs2   = rs2_val;

    case (in_op1_sel)
      OP1_RS1: out_d.op1 = rs1_val;
      OP1_PC:  out_d.op1 = in_pc;
      OP1_IMZ: out_d.op1 = in_imm_z;
      default: out_d.op1 = '0;
    endcase

    case (in_op2_sel)
      OP2_RS2: out_d.op2 = rs2_val;
      OP2_IMI: out_d.op2 = in_imm_i;
      OP2_IMS: out_d.op2 = in_imm_s;
      OP2_IMJ: out_d.op2 = in_imm_j;
      OP2_IMU: out_d.op2 = in_imm_u;
      default: out_d.op2 = '0;
    endcase
  end

  // Flush wins over load/hold; data registers change only when an instruction is taken.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      // NOTE: the payload is reset too so execute never sees X operands after reset.
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_q       <= out_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;
  assign out_id    = out_q.id;
  assign out_ctrl  = out_q.ctrl;
  assign out_imm_i = out_q.imm_i;
  assign out_imm_b = out_q.imm_b;
  assign out_imm_j = out_q.imm_j;
  assign out_op1   = out_q.op1;
  assign out_op2   = out_q.op2;
  assign out_rs2   = out_q.rs2;

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage: directed scenarios plus random traffic checked
// against a transaction-level reference model; a CNT_W=4 copy checks saturation.
module tb_operand_select_stage;

  localparam int XLEN = 32, NUM_FW = 3, RA_W = 5, ID_W = 64, CTRL_W = 48;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, flush, out_ready;
  logic [XLEN-1:0] in_pc, in_imm_i, in_imm_s, in_imm_b, in_imm_j, in_imm_u, in_imm_z;
  logic [31:0] in_inst;
  logic [ID_W-1:0] in_id;
  logic [CTRL_W-1:0] in_ctrl;
  logic [1:0] in_op1_sel;
  logic [2:0] in_op2_sel;
  logic [XLEN-1:0] rf_rs1_rdata, rf_rs2_rdata;
  logic [NUM_FW-1:0] fw_valid, fw_can_forward;
  logic [NUM_FW*RA_W-1:0] fw_addr;
  logic [NUM_FW*XLEN-1:0] fw_wdata;

  logic in_ready, out_valid;
  logic [RA_W-1:0] rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0] out_pc, out_imm_i, out_imm_b, out_imm_j, out_op1, out_op2, out_rs2;
  logic [31:0] out_inst;
  logic [ID_W-1:0] out_id;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0] stall_cnt;

  logic s_in_ready, s_out_valid;
  logic [RA_W-1:0] s_rs1_addr, s_rs2_addr;
  logic [XLEN-1:0] s_pc, s_imm_i, s_imm_b, s_imm_j, s_op1, s_op2, s_rs2;
  logic [31:0] s_inst;
  logic [ID_W-1:0] s_id;
  logic [CTRL_W-1:0] s_ctrl;
  logic [3:0] s_stall_cnt;

  always #5 clk = ~clk;

  operand_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_id(in_id), .in_ctrl(in_ctrl),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_imm_i(in_imm_i), .in_imm_s(in_imm_s), .in_imm_b(in_imm_b),
    .in_imm_j(in_imm_j), .in_imm_u(in_imm_u), .in_imm_z(in_imm_z),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_rdata(rf_rs1_rdata), .rf_rs2_rdata(rf_rs2_rdata),
    .fw_valid(fw_valid), .fw_can_forward(fw_can_forward),
    .fw_addr(fw_addr), .fw_wdata(fw_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_id(out_id), .out_ctrl(out_ctrl),
    .out_imm_i(out_imm_i), .out_imm_b(out_imm_b), .out_imm_j(out_imm_j),
    .out_op1(out_op1), .out_op2(out_op2), .out_rs2(out_rs2),
    .stall_cnt(stall_cnt)
  );

  operand_select_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_id(in_id), .in_ctrl(in_ctrl),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_imm_i(in_imm_i), .in_imm_s(in_imm_s), .in_imm_b(in_imm_b),
    .in_imm_j(in_imm_j), .in_imm_u(in_imm_u), .in_imm_z(in_imm_z),
    .rf_rs1_addr(s_rs1_addr), .rf_rs2_addr(s_rs2_addr),
    .rf_rs1_rdata(rf_rs1_rdata), .rf_rs2_rdata(rf_rs2_rdata),
    .fw_valid(fw_valid), .fw_can_forward(fw_can_forward),
    .fw_addr(fw_addr), .fw_wdata(fw_wdata), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_pc), .out_inst(s_inst), .out_id(s_id), .out_ctrl(s_ctrl),
    .out_imm_i(s_imm_i), .out_imm_b(s_imm_b), .out_imm_j(s_imm_j),
    .out_op1(s_op1), .out_op2(s_op2), .out_rs2(s_rs2),
    .stall_cnt(s_stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected registered state of the stage.
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_imm_i, m_imm_b, m_imm_j, m_op1, m_op2, m_rs2;
  logic [31:0]     m_inst;
  logic [ID_W-1:0] m_id;
  logic [CTRL_W-1:0] m_ctrl;
  int unsigned     m_cnt;
  int unsigned     m_cnt_s;
  logic            obs_ready;

  function automatic logic [XLEN-1:0] src_value(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return '0;
    for (int k = 0; k < NUM_FW; k++)
      if (fw_valid[k] && fw_addr[k*RA_W +: RA_W] == rs) return fw_wdata[k*XLEN +: XLEN];
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic [4:0] a, b;
    a = in_inst[19:15];
    b = in_inst[24:20];
    if (!in_valid) return 1'b0;
    for (int k = 0; k < NUM_FW; k++) begin
      if (fw_valid[k] && !fw_can_forward[k] &&
          ((a != 0 && fw_addr[k*RA_W +: RA_W] == a) || (b != 0 && fw_addr[k*RA_W +: RA_W] == b)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("s_out_valid", s_out_valid, m_valid);
    check("stall_cnt", stall_cnt, m_cnt);
    check("s_stall_cnt", s_stall_cnt, m_cnt_s);
    check("out_pc", out_pc, m_pc);
    check("out_inst", out_inst, m_inst);
    check("out_id", out_id, m_id);
    check("out_ctrl", out_ctrl, m_ctrl);
    check("out_imm_i", out_imm_i, m_imm_i);
    check("out_imm_b", out_imm_b, m_imm_b);
    check("out_imm_j", out_imm_j, m_imm_j);
    check("out_op1", out_op1, m_op1);
    check("out_op2", out_op2, m_op2);
    check("out_rs2", out_rs2, m_rs2);
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registers after the edge.
  task automatic tick();
    logic hz, exp_ready;
    @(negedge clk);
    hz = model_hazard();
    exp_ready = !hz && !flush && (!m_valid || out_ready);
    obs_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
    check("s_in_ready", s_in_ready, exp_ready);
    check("rf_rs1_addr", rf_rs1_addr, in_inst[19:15]);
    check("rf_rs2_addr", rf_rs2_addr, in_inst[24:20]);
    if (reset) begin
      m_valid = 0; m_pc = 0; m_inst = 0; m_id = 0; m_ctrl = 0;
      m_imm_i = 0; m_imm_b = 0; m_imm_j = 0; m_op1 = 0; m_op2 = 0; m_rs2 = 0;
      m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (hz && !flush) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_cnt_s != 15) m_cnt_s++;
      end
      if (flush) m_valid = 0;
      else if (in_valid && exp_ready) begin
        m_valid = 1;
        m_pc = in_pc; m_inst = in_inst; m_id = in_id; m_ctrl = in_ctrl;
        m_imm_i = in_imm_i; m_imm_b = in_imm_b; m_imm_j = in_imm_j;
        m_rs2 = src_value(in_inst[24:20], rf_rs2_rdata);
        case (in_op1_sel)
          2'd0: m_op1 = src_value(in_inst[19:15], rf_rs1_rdata);
          2'd1: m_op1 = in_pc;
          2'd2: m_op1 = in_imm_z;
          default: m_op1 = 0;
        endcase
        case (in_op2_sel)
          3'd0: m_op2 = m_rs2;
          3'd1: m_op2 = in_imm_i;
          3'd2: m_op2 = in_imm_s;
          3'd3: m_op2 = in_imm_j;
          3'd4: m_op2 = in_imm_u;
          default: m_op2 = 0;
        endcase
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] id,
                          input logic [1:0] s1, input logic [2:0] s2);
    in_inst = $urandom;
    in_inst[19:15] = rs1;
    in_inst[24:20] = rs2;
    in_id = id;
    in_ctrl = {$urandom, $urandom};
    in_pc = $urandom;
    in_imm_i = $urandom; in_imm_s = $urandom; in_imm_b = $urandom;
    in_imm_j = $urandom; in_imm_u = $urandom; in_imm_z = $urandom;
    rf_rs1_rdata = $urandom; rf_rs2_rdata = $urandom;
    in_op1_sel = s1;
    in_op2_sel = s2;
  endtask

  task automatic set_fw(input int k, input logic v, input logic cf, input logic [4:0] a,
                        input logic [31:0] d);
    fw_valid[k] = v;
    fw_can_forward[k] = cf;
    fw_addr[k*RA_W +: RA_W] = a;
    fw_wdata[k*XLEN +: XLEN] = d;
  endtask

  logic [63:0] held_id;
  int unsigned cnt_before;

  initial begin
    reset = 1; in_valid = 0; flush = 0; out_ready = 1;
    fw_valid = 0; fw_can_forward = 0; fw_addr = 0; fw_wdata = 0;
    set_inst(0, 0, 0, 0, 0);
    m_valid = 0; m_cnt = 0; m_cnt_s = 0;
    tick(); tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_op1", out_op1, 0);
    check("reset_stall", stall_cnt, 0);
    reset = 0;

    // PC + immediate operands
    set_inst(0, 0, 1, 2'd1, 3'd1);
    in_pc = 32'h8000_0000; in_imm_i = 32'h10; in_valid = 1;
    tick();
    check("pc_valid", out_valid, 1);
    check("pc_op1", out_op1, 32'h8000_0000);
    check("pc_op2", out_op2, 32'h10);
    check("pc_stall", stall_cnt, 0);

    // forwarding priority on rs1=5
    set_inst(5, 0, 2, 2'd0, 3'd1);
    set_fw(0, 1, 1, 5, 32'hAAAA);
    set_fw(2, 1, 1, 5, 32'hBBBB);
    tick();
    check("fw_youngest", out_op1, 32'hAAAA);
    set_fw(0, 0, 1, 5, 32'hAAAA);
    in_id = 3;
    tick();
    check("fw_older", out_op1, 32'hBBBB);
    fw_valid = 0;
    rf_rs1_rdata = 32'h1234; in_id = 4;
    tick();
    check("fw_regfile", out_op1, 32'h1234);

    // non-forwardable hazard on rs2=7 for 3 cycles
    set_inst(0, 7, 5, 2'd0, 3'd0);
    set_fw(1, 1, 0, 7, 32'h7777);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("haz_ready", obs_ready, 0);
    end
    check("haz_cnt", stall_cnt, 3);
    check("haz_drained", out_valid, 0);
    fw_valid = 0;
    tick();
    check("haz_issue_ready", obs_ready, 1);
    check("haz_issue_valid", out_valid, 1);
    check("haz_issue_id", out_id, 5);
    check("haz_cnt_hold", stall_cnt, 3);

    // x0 never stalls or forwards
    set_inst(0, 0, 6, 2'd0, 3'd0);
    set_fw(0, 1, 0, 0, 32'hDEAD);
    tick();
    check("x0_ready", obs_ready, 1);
    check("x0_op1", out_op1, 0);
    check("x0_cnt", stall_cnt, 3);
    fw_valid = 0;

    // backpressure, then 4 back-to-back transfers
    held_id = out_id;
    out_ready = 0;
    set_inst(1, 2, 100, 2'd0, 3'd0);
    tick();
    check("bp_ready", obs_ready, 0);
    check("bp_hold_id", out_id, held_id);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_inst(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 100 + i, 2'd0, 3'd0);
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_id", out_id, 100 + i);
    end

    // flush against held output and pending hazarded input
    out_ready = 0;
    cnt_before = stall_cnt;
    set_inst(3, 0, 200, 2'd0, 3'd0);
    set_fw(0, 1, 0, 3, 32'h3333);
    flush = 1;
    tick();
    check("flush_ready", obs_ready, 0);
    check("flush_valid", out_valid, 0);
    check("flush_cnt", stall_cnt, cnt_before);
    check("flush_id_kept", out_id, 103);
    flush = 0;

    // saturation of the 4-bit counter, then reset mid-stall
    for (int i = 0; i < 20; i++) tick();
    check("sat_small", s_stall_cnt, 15);
    check("sat_wide", stall_cnt, cnt_before + 20);
    reset = 1;
    tick();
    check("rst_cnt", stall_cnt, 0);
    check("rst_cnt_small", s_stall_cnt, 0);
    check("rst_valid", out_valid, 0);
    reset = 0;
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      set_inst(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
               2'($urandom), 3'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NUM_FW; k++)
        set_fw(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
               5'($urandom_range(0, 3)), $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
